vga_tile_ram_arbiter: RTL and testbench

- Shares one single-port tile RAM between the VGA scan-out fetch path and the game-logic writer (snake body, food, score tiles).
- Display reads have absolute priority. Game writes are buffered in a small FIFO and retired in cycles with no display read.
- Sits between the pixel-address logic driven by the h/v sync counters and the tile RAM.
- Reports FIFO occupancy and a sticky starvation flag so game logic can throttle.

---
 rtl/vga_tile_ram_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_vga_tile_ram_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_tile_ram_arbiter.sv
// ---------------------------------------------------------------------------
// vga_tile_ram_arbiter
//
// Shares one single-port tile RAM between the VGA scan-out fetch path and the
// game-logic writer. Display reads always win the port. Game writes go into a
// small FIFO and are written to RAM only in cycles with no display read. The
// block also reports FIFO occupancy and a sticky starvation flag so the game
// logic can slow down.
//
// Ports:
//   clk, rst_n           clock (rising edge) and asynchronous active-low reset
//   vid_req, vid_addr    display read request and tile address
//   vid_valid, vid_data  read result, one cycle after each vid_req cycle
//   wr_valid, wr_ready   game write handshake (accepted on wr_valid & wr_ready)
//   wr_addr, wr_data     game write address and tile code
//   ram_en, ram_we       RAM access strobe and write enable (0 = read)
//   ram_addr, ram_wdata  RAM address and write data
//   ram_rdata            RAM read data, valid one cycle after a read
//   fifo_level           number of writes currently queued
//   wr_starve            sticky flag: queued writes waited too long
//   starve_clr           clears wr_starve and the starvation counter
// ---------------------------------------------------------------------------
module vga_tile_ram_arbiter #(
    parameter int AW           = 11,
    parameter int DW           = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int STARVE_LIMIT = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        vid_req,
    input  logic [AW-1:0]               vid_addr,
    output logic                        vid_valid,
    output logic [DW-1:0]               vid_data,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [AW-1:0]               wr_addr,
    input  logic [DW-1:0]               wr_data,
    output logic                        ram_en,
    output logic                        ram_we,
    output logic [AW-1:0]               ram_addr,
    output logic [DW-1:0]               ram_wdata,
    input  logic [DW-1:0]               ram_rdata,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        wr_starve,
    input  logic                        starve_clr
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [PW:0]   DEPTH_L      = (PW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] LIMIT_L      = CW'(STARVE_LIMIT);
    localparam logic [CW-1:0] LIMIT_LESS_1 = CW'(STARVE_LIMIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } grant_t;

    grant_t              state;
    grant_t              grant;
    logic [AW+DW-1:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_ptr;
    logic [PW:0]         level;
    logic                push;
    logic                pop;
    logic [CW-1:0]       starve_cnt;
    logic [DW-1:0]       vid_data_q;

    assign fifo_level = level;
    assign wr_ready   = (level < DEPTH_L);
    assign push       = wr_valid & wr_ready;
    assign pop        = (grant == WRITE);

    // State register: remembers what the RAM port did last cycle, which
    // decides whether ram_rdata is meaningful this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= grant;
        end
    end

    // Next-state / grant: display first, then the FIFO head, else idle.
    // Reset forces IDLE so no RAM access leaks out while rst_n is low, even
    // before the registers have been cleared by the first clock.
    always_comb begin
        grant = IDLE;
        if (!rst_n) begin
            grant = IDLE;
        end else if (vid_req) begin
            grant = READ;
        end else if (level != '0) begin
            grant = WRITE;
        end
    end

    // Output logic: RAM port driven straight from the current grant. Read
    // data is forwarded in the cycle after a READ so the display sees a fixed
    // one-cycle latency; in other cycles the last returned tile is held.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (grant)
            READ: begin
                ram_en   = 1'b1;
                ram_addr = vid_addr;
            end
            WRITE: begin
                ram_en                = 1'b1;
                ram_we                = 1'b1;
                {ram_addr, ram_wdata} = fifo_mem[rd_ptr];
            end
            default: begin
            end
        endcase
        vid_valid = (state == READ);
        vid_data  = (state == READ) ? ram_rdata : vid_data_q;
    end

    // Holding register for the last tile code returned to the display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vid_data_q <= '0;
        end else if (state == READ) begin
            vid_data_q <= ram_rdata;
        end
    end

    // FIFO storage. Contents need no reset: the pointers and level decide
    // what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {wr_addr, wr_data};
        end
    end

    // FIFO pointers and occupancy. Depth is a power of two, so the pointers
    // wrap on their own. A push and pop together leave the level unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (PW + 1)'(1);
                2'b01:   level <= level - (PW + 1)'(1);
                default: level <= level;
            endcase
        end
    end

    // Starvation tracking: count cycles where writes are waiting but the
    // display holds the port. The flag is sticky until starve_clr, and the
    // clear takes precedence over a set arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            wr_starve  <= 1'b0;
        end else if (starve_clr) begin
            starve_cnt <= '0;
            wr_starve  <= 1'b0;
        end else if (level == '0 || grant != READ) begin
            starve_cnt <= '0;
        end else if (starve_cnt != LIMIT_L) begin
            starve_cnt <= starve_cnt + CW'(1);
            if (starve_cnt == LIMIT_LESS_1) begin
                wr_starve <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_tile_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vga_tile_ram_arbiter
//
// Bench for vga_tile_ram_arbiter. A simple registered-read RAM is attached to
// the DUT's RAM port. A reference model keeps the pending writes in a queue
// and the expected RAM contents in an array, and predicts every output each
// cycle. A table of hand-written vectors covers the basic read and write
// paths; hand sequences cover FIFO full, starvation and mid-drain reset; a
// randomized phase covers the rest.
// ---------------------------------------------------------------------------
module tb_vga_tile_ram_arbiter;

    localparam int AW    = 11;
    localparam int DW    = 4;
    localparam int DEPTH = 8;
    localparam int LIMIT = 16;
    localparam int LW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic          vid_valid;
    logic [DW-1:0] vid_data;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic [LW-1:0] fifo_level;
    logic          wr_starve;
    logic          starve_clr = 1'b0;

    vga_tile_ram_arbiter #(
        .AW(AW), .DW(DW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .vid_req(vid_req), .vid_addr(vid_addr),
        .vid_valid(vid_valid), .vid_data(vid_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .fifo_level(fifo_level), .wr_starve(wr_starve),
        .starve_clr(starve_clr)
    );

    always #5 clk = ~clk;

    // Tile RAM: single port, read data registered one cycle after the read.
    logic [DW-1:0] ram_mem [2**AW] = '{default: '0};
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= ram_mem[ram_addr];
        end
    end

    // Reference model state.
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           model_q [$];
    logic [DW-1:0] model_mem [2**AW] = '{default: '0};
    int            m_cnt;
    bit            m_starve;
    bit            m_prev_read;
    logic [DW-1:0] m_rd_val;
    logic [DW-1:0] m_held;

    int    n_cmp = 0;
    int    n_fail = 0;
    string phase = "init";

    typedef struct {
        logic          vid_req;
        logic [AW-1:0] vid_addr;
        logic          wr_valid;
        logic [AW-1:0] wr_addr;
        logic [DW-1:0] wr_data;
        logic          starve_clr;
        logic          e_en;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic          e_vvalid;
        logic [DW-1:0] e_vdata;
        logic [LW-1:0] e_level;
        logic          e_ready;
    } vec_t;

    vec_t table_v [17];

    function automatic vec_t mkVec(
        input logic vr, input logic [AW-1:0] va,
        input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
        input logic en, input logic we, input logic [AW-1:0] ea,
        input logic [DW-1:0] ewd, input logic vv, input logic [DW-1:0] vd,
        input logic [LW-1:0] lv, input logic rdy);
        vec_t v;
        v.vid_req = vr;  v.vid_addr = va;  v.wr_valid = wv;
        v.wr_addr = wa;  v.wr_data = wd;   v.starve_clr = 1'b0;
        v.e_en = en;     v.e_we = we;      v.e_addr = ea;   v.e_wdata = ewd;
        v.e_vvalid = vv; v.e_vdata = vd;   v.e_level = lv;  v.e_ready = rdy;
        return v;
    endfunction

    function automatic vec_t mkIn(
        input logic vr, input logic [AW-1:0] va,
        input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
        input logic clr);
        vec_t v;
        v = mkVec(vr, va, wv, wa, wd, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        v.starve_clr = clr;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s/%s @%0t: got 0x%0h, expected 0x%0h",
                     phase, name, $time, act, exp);
        end
    endtask

    task automatic modelReset();
        model_q.delete();
        m_cnt       = 0;
        m_starve    = 0;
        m_prev_read = 0;
        m_rd_val    = '0;
        m_held      = '0;
    endtask

    // One clock cycle: drive at the falling edge, check shortly after, then
    // advance the model across the rising edge. Returns at the next falling
    // edge. With use_table set, the vector's own expectations are used
    // instead of the model's (the model still advances).
    task automatic applyStimulus(input vec_t v, input bit use_table);
        int            g;
        int            lvl;
        bit            push_ok;
        logic          x_en, x_we, x_vv, x_rdy;
        logic [AW-1:0] x_addr;
        logic [DW-1:0] x_wd, x_vd;
        logic [LW-1:0] x_lvl;

        vid_req    = v.vid_req;
        vid_addr   = v.vid_addr;
        wr_valid   = v.wr_valid;
        wr_addr    = v.wr_addr;
        wr_data    = v.wr_data;
        starve_clr = v.starve_clr;
        #1;

        lvl = model_q.size();
        if (v.vid_req)    g = 1;
        else if (lvl > 0) g = 2;
        else              g = 0;

        x_en   = (g != 0);
        x_we   = (g == 2);
        x_addr = '0;
        x_wd   = '0;
        if (g == 1) x_addr = v.vid_addr;
        if (g == 2) begin
            x_addr = model_q[0].a;
            x_wd   = model_q[0].d;
        end
        x_vv  = m_prev_read;
        x_vd  = m_prev_read ? m_rd_val : m_held;
        x_lvl = LW'(lvl);
        x_rdy = (lvl < DEPTH);

        if (use_table) begin
            x_en = v.e_en;  x_we = v.e_we;  x_addr = v.e_addr; x_wd = v.e_wdata;
            x_vv = v.e_vvalid; x_vd = v.e_vdata; x_lvl = v.e_level; x_rdy = v.e_ready;
        end

        checkOutput("ram_en",     ram_en,     x_en);
        checkOutput("ram_we",     ram_we,     x_we);
        checkOutput("ram_addr",   ram_addr,   x_addr);
        checkOutput("ram_wdata",  ram_wdata,  x_wd);
        checkOutput("vid_valid",  vid_valid,  x_vv);
        checkOutput("vid_data",   vid_data,   x_vd);
        checkOutput("fifo_level", fifo_level, x_lvl);
        checkOutput("wr_ready",   wr_ready,   x_rdy);
        checkOutput("wr_starve",  wr_starve,  m_starve);

        @(posedge clk);
        push_ok = v.wr_valid && (lvl < DEPTH);
        if (m_prev_read) m_held = m_rd_val;
        if (g == 1) m_rd_val = model_mem[v.vid_addr];
        m_prev_read = (g == 1);
        if (g == 2) begin
            model_mem[model_q[0].a] = model_q[0].d;
            void'(model_q.pop_front());
        end
        if (push_ok) model_q.push_back('{a: v.wr_addr, d: v.wr_data});
        if (v.starve_clr) begin
            m_cnt    = 0;
            m_starve = 0;
        end else if (lvl == 0 || g != 1) begin
            m_cnt = 0;
        end else begin
            if (m_cnt < LIMIT) m_cnt++;
            if (m_cnt == LIMIT) m_starve = 1;
        end
        @(negedge clk);
    endtask

    task automatic randomCycle(input int vid_pct);
        vec_t v;
        v = mkIn($urandom_range(99) < vid_pct, AW'($urandom),
                 $urandom_range(1), AW'($urandom), DW'($urandom),
                 $urandom_range(31) == 0);
        applyStimulus(v, 0);
    endtask

    initial begin
        int   rise;
        vec_t v;

        // Reset with both requesters active.
        phase    = "reset";
        vid_req  = 1'b1;
        vid_addr = 11'h010;
        wr_valid = 1'b1;
        wr_addr  = 11'h010;
        wr_data  = 4'h3;
        modelReset();
        repeat (3) @(negedge clk);
        #1;
        checkOutput("vid_valid",  vid_valid,  0);
        checkOutput("vid_data",   vid_data,   0);
        checkOutput("ram_en",     ram_en,     0);
        checkOutput("ram_we",     ram_we,     0);
        checkOutput("ram_addr",   ram_addr,   0);
        checkOutput("ram_wdata",  ram_wdata,  0);
        checkOutput("fifo_level", fifo_level, 0);
        checkOutput("wr_ready",   wr_ready,   1);
        checkOutput("wr_starve",  wr_starve,  0);
        rst_n = 1'b1;

        // Table: load three tiles, read them back, then stream 8 writes.
        table_v[0] = mkVec(1, 11'h010, 1, 11'h010, 4'h3, 1, 0, 11'h010, 0, 0, 0, 0, 1);
        table_v[1] = mkVec(0, 11'h000, 1, 11'h011, 4'h5, 1, 1, 11'h010, 3, 1, 0, 1, 1);
        table_v[2] = mkVec(0, 11'h000, 1, 11'h012, 4'h7, 1, 1, 11'h011, 5, 0, 0, 1, 1);
        table_v[3] = mkVec(0, 11'h000, 0, 11'h000, 4'h0, 1, 1, 11'h012, 7, 0, 0, 1, 1);
        table_v[4] = mkVec(1, 11'h010, 0, 11'h000, 4'h0, 1, 0, 11'h010, 0, 0, 0, 0, 1);
        table_v[5] = mkVec(1, 11'h011, 0, 11'h000, 4'h0, 1, 0, 11'h011, 0, 1, 3, 0, 1);
        table_v[6] = mkVec(1, 11'h012, 0, 11'h000, 4'h0, 1, 0, 11'h012, 0, 1, 5, 0, 1);
        table_v[7] = mkVec(0, 11'h000, 1, 11'h100, 4'h0, 0, 0, 11'h000, 0, 1, 7, 0, 1);
        for (int r = 8; r <= 14; r++) begin
            table_v[r] = mkVec(0, 11'h000, 1, AW'(256 + r - 7), DW'(r - 7),
                               1, 1, AW'(256 + r - 8), DW'(r - 8), 0, 7, 1, 1);
        end
        table_v[15] = mkVec(0, 11'h000, 0, 11'h000, 4'h0, 1, 1, 11'h107, 7, 0, 7, 1, 1);
        table_v[16] = mkVec(0, 11'h000, 0, 11'h000, 4'h0, 0, 0, 11'h000, 0, 0, 7, 0, 1);
        phase = "table";
        for (int r = 0; r < 17; r++) applyStimulus(table_v[r], 1);
        for (int i = 0; i < 8; i++) checkOutput("ram_order", ram_mem[256 + i], i);

        // FIFO fills while the display holds the port, then drains in order.
        phase = "fill";
        for (int i = 0; i < 8; i++)
            applyStimulus(mkIn(1, AW'($urandom), 1, AW'(512 + i), DW'(i), 0), 0);
        checkOutput("full_level", fifo_level, 8);
        checkOutput("full_ready", wr_ready, 0);
        applyStimulus(mkIn(1, AW'($urandom), 1, 11'h208, 4'h8, 0), 0);
        applyStimulus(mkIn(0, 11'h000, 1, 11'h208, 4'h8, 0), 0);
        checkOutput("ready_after_pop", wr_ready, 1);
        applyStimulus(mkIn(0, 11'h000, 1, 11'h208, 4'h8, 0), 0);
        for (int i = 0; i < 9; i++) applyStimulus(mkIn(0, 0, 0, 0, 0, 0), 0);
        checkOutput("drained_level", fifo_level, 0);
        for (int i = 0; i < 9; i++) checkOutput("fill_order", ram_mem[512 + i], i);

        // Starvation: one queued write behind 20 display reads.
        phase = "starve";
        applyStimulus(mkIn(1, AW'($urandom), 1, 11'h280, 4'hE, 0), 0);
        rise = -1;
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(mkIn(1, AW'($urandom), 0, 0, 0, 0), 0);
            if (rise < 0 && wr_starve === 1'b1) rise = k;
        end
        checkOutput("starve_rise", rise, 16);
        checkOutput("starve_sticky", wr_starve, 1);
        applyStimulus(mkIn(1, AW'($urandom), 0, 0, 0, 1), 0);
        checkOutput("starve_cleared", wr_starve, 0);
        applyStimulus(mkIn(1, AW'($urandom), 0, 0, 0, 0), 0);
        checkOutput("starve_restart", wr_starve, 0);
        for (int i = 0; i < 2; i++) applyStimulus(mkIn(0, 0, 0, 0, 0, 0), 0);
        checkOutput("starve_write", ram_mem[11'h280], 4'hE);

        // Reset in the middle of draining four queued writes.
        phase = "mid_reset";
        for (int i = 0; i < 4; i++)
            applyStimulus(mkIn(1, AW'($urandom), 1, AW'(768 + i), DW'(9 + i), 0), 0);
        for (int i = 0; i < 2; i++) applyStimulus(mkIn(0, 0, 0, 0, 0, 0), 0);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_ram_en",   ram_en,     0);
        checkOutput("rst_ram_we",   ram_we,     0);
        checkOutput("rst_level",    fifo_level, 0);
        checkOutput("rst_ready",    wr_ready,   1);
        checkOutput("rst_vvalid",   vid_valid,  0);
        modelReset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(mkIn(0, 0, 0, 0, 0, 0), 0);
        checkOutput("kept_w0",    ram_mem[768], 9);
        checkOutput("kept_w1",    ram_mem[769], 10);
        checkOutput("dropped_w2", ram_mem[770], 0);
        checkOutput("dropped_w3", ram_mem[771], 0);

        // Randomized traffic against the model, light then heavy display load.
        phase = "random_light";
        for (int i = 0; i < 300; i++) randomCycle(50);
        phase = "random_heavy";
        for (int i = 0; i < 300; i++) randomCycle(95);
        phase = "random_drain";
        for (int i = 0; i < 12; i++) applyStimulus(mkIn(0, 0, 0, 0, 0, 0), 0);
        for (int a = 0; a < 2**AW; a++) checkOutput("ram_final", ram_mem[a], model_mem[a]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
